// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: load-use stalls,
// redirect flushes, registered EX forwarding selects and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [REG_ADDR_W-1:0]             id_rs1,
    input  logic [REG_ADDR_W-1:0]             id_rs2,
    input  logic                              id_uses_rs1,
    input  logic                              id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]             id_rd,
    input  logic                              id_reg_write,
    input  logic                              id_is_load,
    input  logic                              ex_redirect,
    output logic                              pc_en,
    output logic                              if_id_en,
    output logic                              if_id_clear,
    output logic                              id_ex_clear,
    output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_a_sel,
    output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_b_sel,
    output logic [CNT_W-1:0]                  stall_cnt,
    output logic [CNT_W-1:0]                  flush_cnt
);

    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    // The retiring WB producer is never forwarded or stalled on (write-before-read
    // register file), so only the entries that can influence outputs are stored.
    logic [FWD_STAGES-1:0]   sb_valid_r;
    logic [FWD_STAGES-1:0]   sb_wr_r;
    logic [FWD_STAGES-1:0]   sb_ld_r;
    logic [REG_ADDR_W-1:0]   sb_rd_r [FWD_STAGES];

    logic [FWD_STAGES-1:0]   match_a_s;
    logic [FWD_STAGES-1:0]   match_b_s;
    logic                    load_hit_s;
    logic                    stall_s;
    logic                    bubble_s;
    logic [SEL_W-1:0]        fwd_a_nxt_s;
    logic [SEL_W-1:0]        fwd_b_nxt_s;

    function automatic logic src_match(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  valid,
        input logic                  wr,
        input logic [REG_ADDR_W-1:0] rd
    );
        return used && id_valid && valid && wr && (rd == src) &&
               (rd != {REG_ADDR_W{1'b0}});
    endfunction

    // Source-vs-scoreboard match vectors for both operands
    always_comb begin
        match_a_s = {FWD_STAGES{1'b0}};
        match_b_s = {FWD_STAGES{1'b0}};
        for (int j = 0; j < FWD_STAGES; j++) begin
            match_a_s[j] = src_match(id_uses_rs1, id_rs1, sb_valid_r[j], sb_wr_r[j], sb_rd_r[j]);
            match_b_s[j] = src_match(id_uses_rs2, id_rs2, sb_valid_r[j], sb_wr_r[j], sb_rd_r[j]);
        end
    end

    // Load-use detection; a redirect squashes the wrong-path consumer instead
    always_comb begin
        load_hit_s = 1'b0;
        for (int j = 0; j < FWD_STAGES; j++) begin
            load_hit_s = load_hit_s |
                         ((j < LOAD_STALL) && sb_ld_r[j] && (match_a_s[j] || match_b_s[j]));
        end
        stall_s  = load_hit_s && !ex_redirect;
        bubble_s = stall_s || ex_redirect || !id_valid;
    end

    // Youngest matching producer wins: scan oldest to youngest, last hit sticks
    always_comb begin
        fwd_a_nxt_s = {SEL_W{1'b0}};
        fwd_b_nxt_s = {SEL_W{1'b0}};
        for (int j = FWD_STAGES - 1; j >= 0; j--) begin
            fwd_a_nxt_s = match_a_s[j] ? SEL_W'(j + 1) : fwd_a_nxt_s;
            fwd_b_nxt_s = match_b_s[j] ? SEL_W'(j + 1) : fwd_b_nxt_s;
        end
    end

    // Pipeline enable / clear generation
    always_comb begin
        if (ex_redirect) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
        end else if (stall_s) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_clear = 1'b0;
            id_ex_clear = 1'b1;
        end else begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_clear = 1'b0;
            id_ex_clear = 1'b0;
        end
    end

    // Scoreboard shift with entry-0 load (bubble or the ID instruction)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_valid_r <= {FWD_STAGES{1'b0}};
            sb_wr_r    <= {FWD_STAGES{1'b0}};
            sb_ld_r    <= {FWD_STAGES{1'b0}};
            for (int j = 0; j < FWD_STAGES; j++) begin
                sb_rd_r[j] <= {REG_ADDR_W{1'b0}};
            end
        end else begin
            for (int j = FWD_STAGES - 1; j > 0; j--) begin
                sb_valid_r[j] <= sb_valid_r[j-1];
                sb_wr_r[j]    <= sb_wr_r[j-1];
                sb_ld_r[j]    <= sb_ld_r[j-1];
                sb_rd_r[j]    <= sb_rd_r[j-1];
            end
            if (bubble_s) begin
                sb_valid_r[0] <= 1'b0;
                sb_wr_r[0]    <= 1'b0;
                sb_ld_r[0]    <= 1'b0;
                sb_rd_r[0]    <= {REG_ADDR_W{1'b0}};
            end else begin
                sb_valid_r[0] <= 1'b1;
                sb_wr_r[0]    <= id_reg_write;
                sb_ld_r[0]    <= id_is_load;
                sb_rd_r[0]    <= id_rd;
            end
        end
    end

    // Forwarding selects, registered one cycle ahead of their use in EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_sel <= {SEL_W{1'b0}};
            fwd_b_sel <= {SEL_W{1'b0}};
        end else if (bubble_s) begin
            fwd_a_sel <= {SEL_W{1'b0}};
            fwd_b_sel <= {SEL_W{1'b0}};
        end else begin
            fwd_a_sel <= fwd_a_nxt_s;
            fwd_b_sel <= fwd_b_nxt_s;
        end
    end

    // Saturating stall / flush performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (ex_redirect && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule
